// File: rtl/draw_menu_char.sv
// Menu text overlay: a 16x16-character window of 8x16 glyphs merged into the VGA stream.
// Four-stage pipeline that lines up with the 1-cycle text ROM and the 1-cycle font ROM.
module draw_menu_char #(
  parameter int          X_POS      = 100,
  parameter int          Y_POS      = 200,
  parameter logic [11:0] TEXT_COLOR = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [7:0]  char_pixels,
  output logic [7:0]  char_xy,
  output logic [3:0]  char_line,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [11:0] X_LO = 12'(X_POS);
  localparam logic [11:0] X_HI = 12'(X_POS + 128);
  localparam logic [11:0] Y_LO = 12'(Y_POS);
  localparam logic [11:0] Y_HI = 12'(Y_POS + 256);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } timing_t;

  logic       in_region;
  logic [6:0] rel_x;
  logic [7:0] rel_y;

  // The region test uses full-width unsigned bounds, so the coordinates to the left of or above the
  // window cannot wrap into it. The offsets only need their low bits, and those low bits do not
  // depend on the high bits of the operands.
  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    in_region = ({1'b0, hcount_in} >= X_LO) && ({1'b0, hcount_in} < X_HI) &&
                ({1'b0, vcount_in} >= Y_LO) && ({1'b0, vcount_in} < Y_HI);
    rel_x     = hcount_in[6:0] - X_LO[6:0];
    rel_y     = vcount_in[7:0] - Y_LO[7:0];
  end

  timing_t    tim_in, tim_s1, tim_s2, tim_s3, tim_out;
  logic       in_s1, in_s2, in_s3;
  logic [2:0] xoff_s1, xoff_s2, xoff_s3;
  logic [3:0] line_s1;
  logic [11:0] rgb_s1, rgb_s2, rgb_s3;
  logic       glyph_bit;

  assign tim_in    = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
  assign glyph_bit = char_pixels[3'd7 - xoff_s3];

  // NOTE: pipeline state uses non-blocking assignments, so each stage samples the value its
  // predecessor held before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tim_s1    <= '0;
      tim_s2    <= '0;
      tim_s3    <= '0;
      tim_out   <= '0;
      in_s1     <= 1'b0;
      in_s2     <= 1'b0;
      in_s3     <= 1'b0;
      xoff_s1   <= '0;
      xoff_s2   <= '0;
      xoff_s3   <= '0;
      line_s1   <= '0;
      rgb_s1    <= '0;
      rgb_s2    <= '0;
      rgb_s3    <= '0;
      char_xy   <= '0;
      char_line <= '0;
      rgb_out   <= '0;
    end else begin
      tim_s1    <= tim_in;
      in_s1     <= in_region;
      xoff_s1   <= in_region ? rel_x[2:0] : 3'd0;
      line_s1   <= in_region ? rel_y[3:0] : 4'd0;
      char_xy   <= in_region ? {rel_y[7:4], rel_x[6:3]} : 8'h00;
      rgb_s1    <= rgb_in;

      // char_line is held back one cycle so that it reaches the font ROM together with char_code.
      tim_s2    <= tim_s1;
      in_s2     <= in_s1;
      xoff_s2   <= xoff_s1;
      char_line <= line_s1;
      rgb_s2    <= rgb_s1;

      tim_s3    <= tim_s2;
      in_s3     <= in_s2;
      xoff_s3   <= xoff_s2;
      rgb_s3    <= rgb_s2;

      tim_out   <= tim_s3;
      rgb_out   <= (in_s3 && glyph_bit) ? TEXT_COLOR : rgb_s3;
    end
  end

  assign hcount_out = tim_out.hcount;
  assign vcount_out = tim_out.vcount;
  assign hsync_out  = tim_out.hsync;
  assign vsync_out  = tim_out.vsync;
  assign hblnk_out  = tim_out.hblnk;
  assign vblnk_out  = tim_out.vblnk;

endmodule

// File: tb/tb_draw_menu_char.sv
// Scoreboard bench for draw_menu_char: the driver queues the expected responses, and a monitor pops
// and compares them when each pixel's result emerges.
module tb_draw_menu_char;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [7:0]  char_pixels;
  logic [7:0]  char_xy;
  logic [3:0]  char_line;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  draw_menu_char #(.X_POS(100), .Y_POS(200), .TEXT_COLOR(12'hFFF)) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .char_pixels(char_pixels),
    .char_xy(char_xy), .char_line(char_line),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic [3:0]  syncs;
    logic [11:0] rgb;
  } out_t;

  logic [7:0] xy_q[$];
  logic [3:0] line_q[$];
  out_t       out_q[$];
  logic [7:0] pix_q[$];

  // issue marks a cycle that carries a tracked vector; vld follows it down the pipeline.
  logic       issue = 1'b0;
  logic [3:0] vld;

  always @(posedge clk or posedge rst)
    if (rst) vld <= '0;
    else     vld <= {vld[2:0], issue};

  // Font ROM model: returns the glyph row queued for the pixel issued three cycles earlier.
  always @(posedge clk) begin
    #1;
    if (vld[2] && pix_q.size() > 0) char_pixels = pix_q.pop_front();
    else                            char_pixels = 8'h00;
  end

  // Monitor: compares each output stage against its queue at the moment that stage becomes valid.
  always @(negedge clk) begin
    if (!rst) begin
      if (vld[0]) begin
        if (xy_q.size() == 0) check("xy_queue_empty", 32'd0, 32'd1);
        else check("char_xy", 32'(char_xy), 32'(xy_q.pop_front()));
      end
      if (vld[1]) begin
        if (line_q.size() == 0) check("line_queue_empty", 32'd0, 32'd1);
        else check("char_line", 32'(char_line), 32'(line_q.pop_front()));
      end
      if (vld[3]) begin
        if (out_q.size() == 0) check("out_queue_empty", 32'd0, 32'd1);
        else begin
          out_t e;
          e = out_q.pop_front();
          check("hcount_out", 32'(hcount_out), 32'(e.hcount));
          check("vcount_out", 32'(vcount_out), 32'(e.vcount));
          check("sync_blank_out", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'(e.syncs));
          check("rgb_out", 32'(rgb_out), 32'(e.rgb));
        end
      end
    end
  end

  // Drives one pixel for one clock and queues the expected char_xy, char_line and output values
  // for that pixel.
  task automatic send(input logic [10:0] h, input logic [10:0] v, input logic [3:0] syncs,
                      input logic [11:0] rgb, input logic [7:0] pix,
                      input logic [7:0] exp_xy, input logic [3:0] exp_line, input logic [11:0] exp_rgb);
    out_t e;
    hcount_in = h;
    vcount_in = v;
    {hsync_in, vsync_in, hblnk_in, vblnk_in} = syncs;
    rgb_in = rgb;
    issue  = 1'b1;
    xy_q.push_back(exp_xy);
    line_q.push_back(exp_line);
    pix_q.push_back(pix);
    e.hcount = h;
    e.vcount = v;
    e.syncs  = syncs;
    e.rgb    = exp_rgb;
    out_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    issue = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    hcount_in = '0; vcount_in = '0;
    hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0;
    rgb_in = '0; char_pixels = '0;
    #12;
    check("reset_rgb_out", 32'(rgb_out), 32'h0);
    check("reset_char_xy", 32'(char_xy), 32'h0);
    check("reset_char_line", 32'(char_line), 32'h0);
    check("reset_hcount_out", 32'(hcount_out), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Region origin.
    send(11'd100, 11'd200, 4'b1010, 12'h123, 8'h80, 8'h00, 4'd0, 12'hFFF);
    send(11'd100, 11'd200, 4'b0101, 12'h123, 8'h7F, 8'h00, 4'd0, 12'h123);
    // Interior cell: rel_x=43 (col 5, xoff 3), rel_y=71 (row 4, line 7).
    send(11'd143, 11'd271, 4'b0000, 12'h0A5, 8'h10, 8'h45, 4'd7, 12'hFFF);
    send(11'd143, 11'd271, 4'b1111, 12'h0A5, 8'hEF, 8'h45, 4'd7, 12'h0A5);
    // Interior cell: rel_x=50 (col 6, xoff 2), rel_y=50 (row 3, line 2).
    send(11'd150, 11'd250, 4'b0011, 12'h321, 8'h20, 8'h36, 4'd2, 12'hFFF);
    // Right edge at row 6, line 4, then one pixel past it.
    send(11'd227, 11'd300, 4'b0000, 12'h00F, 8'hFF, 8'h6F, 4'd4, 12'hFFF);
    send(11'd228, 11'd300, 4'b0000, 12'h00F, 8'hFF, 8'h00, 4'd0, 12'h00F);
    // Bottom edge at row 15, line 15, then one line past it.
    send(11'd227, 11'd455, 4'b1000, 12'h00F, 8'hFF, 8'hFF, 4'd15, 12'hFFF);
    send(11'd228, 11'd455, 4'b1000, 12'h00F, 8'hFF, 8'h00, 4'd0, 12'h00F);
    send(11'd227, 11'd456, 4'b1000, 12'h00F, 8'hFF, 8'h00, 4'd0, 12'h00F);
    send(11'd100, 11'd456, 4'b1000, 12'h00F, 8'hFF, 8'h00, 4'd0, 12'h00F);
    // Above and left of the origin; these must not wrap into the window.
    send(11'd99,  11'd199, 4'b0110, 12'hABC, 8'hFF, 8'h00, 4'd0, 12'hABC);
    send(11'd99,  11'd250, 4'b0110, 12'hABC, 8'hFF, 8'h00, 4'd0, 12'hABC);
    send(11'd150, 11'd199, 4'b0110, 12'hABC, 8'hFF, 8'h00, 4'd0, 12'hABC);
    send(11'd2047, 11'd2047, 4'b0110, 12'hABC, 8'hFF, 8'h00, 4'd0, 12'hABC);
    idle(6);

    // Timing alignment with random syncs and blanking, outside the window.
    for (int i = 0; i < 1000; i++) begin
      logic [10:0] h;
      logic [10:0] v;
      logic [11:0] c;
      h = 11'($urandom_range(0, 99));
      v = 11'($urandom_range(0, 2047));
      c = 12'($urandom);
      send(h, v, 4'($urandom), c, 8'hFF, 8'h00, 4'd0, c);
    end
    idle(6);

    // Async reset in the middle of a line while the pipeline holds in-region pixels.
    send(11'd143, 11'd271, 4'b1111, 12'h0A5, 8'hFF, 8'h45, 4'd7, 12'hFFF);
    send(11'd150, 11'd250, 4'b1111, 12'h321, 8'hFF, 8'h36, 4'd2, 12'hFFF);
    send(11'd151, 11'd250, 4'b1111, 12'h321, 8'hFF, 8'h36, 4'd2, 12'hFFF);
    send(11'd152, 11'd250, 4'b1111, 12'h321, 8'hFF, 8'h36, 4'd2, 12'hFFF);
    issue = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_rgb_out", 32'(rgb_out), 32'h0);
    check("async_rst_char_xy", 32'(char_xy), 32'h0);
    check("async_rst_char_line", 32'(char_line), 32'h0);
    check("async_rst_hcount_out", 32'(hcount_out), 32'h0);
    check("async_rst_vcount_out", 32'(vcount_out), 32'h0);
    check("async_rst_syncs_out", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'h0);
    xy_q.delete();
    line_q.delete();
    out_q.delete();
    pix_q.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Refill: the first sampled pixel must emerge on the 4th clock.
    send(11'd143, 11'd271, 4'b1010, 12'h0A5, 8'h10, 8'h45, 4'd7, 12'hFFF);
    send(11'd228, 11'd300, 4'b0101, 12'h00F, 8'hFF, 8'h00, 4'd0, 12'h00F);
    send(11'd227, 11'd455, 4'b1100, 12'h00F, 8'hFF, 8'hFF, 4'd15, 12'hFFF);
    send(11'd99,  11'd199, 4'b0011, 12'h777, 8'hFF, 8'h00, 4'd0, 12'h777);
    issue = 1'b0;

    // Drain, with a bounded wait.
    for (int i = 0; i < 20 && (out_q.size() != 0 || xy_q.size() != 0 || line_q.size() != 0); i++)
      @(posedge clk);
    #1;
    check("drain_out_queue", 32'(out_q.size()), 32'd0);
    check("drain_xy_queue", 32'(xy_q.size()), 32'd0);
    check("drain_line_queue", 32'(line_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
